traffic_mode_ctrl: RTL and testbench

Parametrised traffic-mode controller for the intersection's mode register. It extends the fixed two-bit day/night/pedestrian/emergency mode selection with several features:
- NUM_PED latched pedestrian request channels, served round-robin.
- A timed pedestrian dwell.
- A debounced day/night input.
- Emergency preemption with a clear-out hold.

Its outputs drive the light-sequencing logic directly.

---
 rtl/traffic_mode_ctrl.sv | 153 +++++++++++++++
 tb/tb_traffic_mode_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_mode_ctrl.sv
// Intersection mode controller: debounced day/night base mode, round-robin
// pedestrian service with timed dwell, and emergency preemption with clear-out hold.
module traffic_mode_ctrl #(
   parameter int NUM_PED    = 4,
   parameter int PED_CYCLES = 8,
   parameter int EMG_CLEAR  = 4,
   parameter int DEBOUNCE   = 3,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               timeSignal,
   input  logic [NUM_PED-1:0] pedReq,
   input  logic               emgSignal,
   output logic [1:0]         modeOut,
   output logic [NUM_PED-1:0] pedGrant,
   output logic [NUM_PED-1:0] pedPending,
   output logic               modeChange
);

   localparam int PTR_W = (NUM_PED > 1) ? $clog2(NUM_PED) : 1;
   localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_CYCLES - 1);
   localparam logic [CNT_W-1:0] EMG_LIM  = CNT_W'(EMG_CLEAR);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      DAY   = 2'b00,
      NIGHT = 2'b01,
      PED   = 2'b10,
      EMG   = 2'b11
   } mode_t;

   mode_t              mode, modeNext, baseMode;
   logic [NUM_PED-1:0] grantNext, pendingNext;
   logic [CNT_W-1:0]   dwellCnt, dwellNext;
   logic [CNT_W-1:0]   emgCnt, emgNext;
   logic [CNT_W-1:0]   debCnt, debNext;
   logic               timeFlag, timeFlagNext;
   logic [PTR_W-1:0]   rrPtr, rrNext;

   logic               arbFound;
   logic [PTR_W-1:0]   arbIdx;
   logic [NUM_PED-1:0] arbMask;

   function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int step);
      int s;
      s = int'(base) + step;
      if (s >= NUM_PED) s = s - NUM_PED;
      return PTR_W'(s);
   endfunction

   // Round-robin search starts just after the last-served channel; the final
   // step lands back on it, so a lone channel can be served again.
   always_comb begin
      arbFound = 1'b0;
      arbIdx   = rrPtr;
      for (int k = 1; k <= NUM_PED; k++) begin
         if (!arbFound && |(pedPending & (NUM_PED'(1) << wrapIdx(rrPtr, k)))) begin
            arbFound = 1'b1;
            arbIdx   = wrapIdx(rrPtr, k);
         end
      end
      arbMask = arbFound ? (NUM_PED'(1) << arbIdx) : '0;
   end

   always_comb begin
      timeFlagNext = timeFlag;
      debNext      = '0;
      if (timeSignal != timeFlag) begin
         if (debCnt == DEB_LAST) begin
            timeFlagNext = timeSignal;
         end else begin
            debNext = debCnt + 1'b1;
         end
      end
   end

   assign baseMode = timeFlag ? DAY : NIGHT;

   always_comb begin
      modeNext    = mode;
      grantNext   = pedGrant;
      dwellNext   = dwellCnt;
      emgNext     = emgCnt;
      rrNext      = rrPtr;
      pendingNext = pedPending | (pedReq & ~pedGrant);

      if (emgSignal) begin
         modeNext    = EMG;
         grantNext   = '0;
         pendingNext = pendingNext | pedGrant;
         emgNext     = '0;
         dwellNext   = '0;
      end else begin
         logic leave;
         leave = 1'b0;
         unique case (mode)
            EMG: begin
               if (emgCnt == EMG_LIM) leave = 1'b1;
               else emgNext = emgCnt + 1'b1;
            end
            PED: begin
               if (dwellCnt == PED_LAST) leave = 1'b1;
               else dwellNext = dwellCnt + 1'b1;
            end
            default: leave = 1'b1;
         endcase

         // A grant clears its pending bit even if the same channel requests on this edge.
         if (leave) begin
            if (arbFound) begin
               modeNext    = PED;
               grantNext   = arbMask;
               rrNext      = arbIdx;
               dwellNext   = '0;
               pendingNext = pendingNext & ~arbMask;
            end else begin
               modeNext  = baseMode;
               grantNext = '0;
               dwellNext = '0;
            end
            emgNext = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode       <= DAY;
         pedGrant   <= '0;
         pedPending <= '0;
         modeChange <= 1'b0;
         dwellCnt   <= '0;
         emgCnt     <= '0;
         debCnt     <= '0;
         timeFlag   <= 1'b1;
         rrPtr      <= PTR_W'(NUM_PED - 1);
      end else begin
         mode       <= modeNext;
         pedGrant   <= grantNext;
         pedPending <= pendingNext;
         modeChange <= (modeNext != mode);
         dwellCnt   <= dwellNext;
         emgCnt     <= emgNext;
         debCnt     <= debNext;
         timeFlag   <= timeFlagNext;
         rrPtr      <= rrNext;
      end
   end

   assign modeOut = mode;

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// Scoreboard bench for traffic_mode_ctrl: default-parameter instance checked
// against a cycle model, plus a minimum-parameter instance with directed checks.
module tb_traffic_mode_ctrl;

   localparam int P_NUM = 4;
   localparam int P_PED = 8;
   localparam int P_EMG = 4;
   localparam int P_DEB = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             timeSignal;
   logic [P_NUM-1:0] pedReq;
   logic             emgSignal;
   logic [1:0]       modeOut;
   logic [P_NUM-1:0] pedGrant;
   logic [P_NUM-1:0] pedPending;
   logic             modeChange;

   logic       rstM, timeM, emgM, chgM;
   logic [0:0] pedM, grantM, pendM;
   logic [1:0] modeM;

   always #5 clk = ~clk;

   traffic_mode_ctrl #(.NUM_PED(P_NUM), .PED_CYCLES(P_PED), .EMG_CLEAR(P_EMG),
                       .DEBOUNCE(P_DEB), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .timeSignal(timeSignal), .pedReq(pedReq),
      .emgSignal(emgSignal), .modeOut(modeOut), .pedGrant(pedGrant),
      .pedPending(pedPending), .modeChange(modeChange));

   traffic_mode_ctrl #(.NUM_PED(1), .PED_CYCLES(1), .EMG_CLEAR(0),
                       .DEBOUNCE(1), .CNT_W(8)) dutMin (
      .clk(clk), .rst_n(rstM), .timeSignal(timeM), .pedReq(pedM),
      .emgSignal(emgM), .modeOut(modeM), .pedGrant(grantM),
      .pedPending(pendM), .modeChange(chgM));

   typedef struct packed {
      logic [1:0]       mode;
      logic [P_NUM-1:0] grant;
      logic [P_NUM-1:0] pend;
      logic             chg;
   } exp_t;

   exp_t  sbq[$];
   int    errors = 0;
   int    checks = 0;
   string curTest = "init";

   int           mMode, mGrant, mLast, mDwellLeft, mEmgLow, mDeb;
   bit           mFlag;
   bit [P_NUM-1:0] mPend;

   function automatic bit [P_NUM-1:0] grantVecOf(input int idx);
      bit [P_NUM-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   function automatic int nextPending(input bit [P_NUM-1:0] p, input int last);
      for (int d = 1; d <= P_NUM; d++) begin
         if (p[(last + d) % P_NUM]) return (last + d) % P_NUM;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mMode = 0; mGrant = -1; mLast = P_NUM - 1; mDwellLeft = 0;
      mEmgLow = 0; mDeb = 0; mFlag = 1'b1; mPend = '0;
   endtask

   task automatic modelStep(output exp_t e);
      bit [P_NUM-1:0] np;
      int oldMode, base, ch;
      bit leave;
      np      = mPend | (pedReq & ~grantVecOf(mGrant));
      oldMode = mMode;
      base    = mFlag ? 0 : 1;
      leave   = 1'b0;
      if (emgSignal) begin
         if (mGrant >= 0) np[mGrant] = 1'b1;
         mGrant = -1; mMode = 3; mEmgLow = 0;
      end else begin
         if (mMode == 3) begin
            if (mEmgLow == P_EMG) leave = 1'b1;
            else mEmgLow++;
         end else if (mMode == 2) begin
            mDwellLeft--;
            if (mDwellLeft == 0) leave = 1'b1;
         end else begin
            leave = 1'b1;
         end
         if (leave) begin
            ch = nextPending(mPend, mLast);
            if (ch >= 0) begin
               mMode = 2; mGrant = ch; mLast = ch; mDwellLeft = P_PED; np[ch] = 1'b0;
            end else begin
               mMode = base; mGrant = -1;
            end
         end
      end
      if (timeSignal != mFlag) begin
         mDeb++;
         if (mDeb == P_DEB) begin mFlag = timeSignal; mDeb = 0; end
      end else begin
         mDeb = 0;
      end
      mPend   = np;
      e.mode  = 2'(mMode);
      e.grant = grantVecOf(mGrant);
      e.pend  = mPend;
      e.chg   = (mMode != oldMode);
   endtask

   // Model predicts at drive time; DUT outputs are compared 1 time unit after the edge.
   task automatic step();
      exp_t e;
      modelStep(e);
      sbq.push_back(e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if (modeOut !== e.mode) begin
         errors++; $display("FAIL %s modeOut got=%b exp=%b t=%0t", curTest, modeOut, e.mode, $time);
      end
      checks++;
      if (pedGrant !== e.grant) begin
         errors++; $display("FAIL %s pedGrant got=%b exp=%b t=%0t", curTest, pedGrant, e.grant, $time);
      end
      checks++;
      if (pedPending !== e.pend) begin
         errors++; $display("FAIL %s pedPending got=%b exp=%b t=%0t", curTest, pedPending, e.pend, $time);
      end
      checks++;
      if (modeChange !== e.chg) begin
         errors++; $display("FAIL %s modeChange got=%b exp=%b t=%0t", curTest, modeChange, e.chg, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic doReset();
      pedReq = '0; emgSignal = 1'b0; timeSignal = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic test_reset();
      curTest = "reset";
      tick();
      checks++;
      if ({modeOut, pedGrant, pedPending, modeChange} !== '0) begin
         errors++; $display("FAIL reset_state got=%b exp=0", {modeOut, pedGrant, pedPending, modeChange});
      end
      rst_n = 1'b1;
      modelReset();
      repeat (3) step();
      pedReq = 4'b0001; step();
      pedReq = 4'b0000; step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({modeOut, pedGrant, pedPending, modeChange} !== '0) begin
         errors++; $display("FAIL reset_mid_dwell got=%b exp=0", {modeOut, pedGrant, pedPending, modeChange});
      end
      tick();
      rst_n = 1'b1;
      modelReset();
      curTest = "reset_idle";
      repeat (8) step();
   endtask

   task automatic test_single_ped();
      int pedCycles, pulses;
      curTest = "single_ped";
      pedCycles = 0; pulses = 0;
      pedReq = 4'b0001; step();
      pedReq = 4'b0000;
      repeat (12) begin
         step();
         if (modeOut == 2'b10 && pedGrant == 4'b0001) pedCycles++;
         if (modeChange) pulses++;
      end
      checks++;
      if (pedCycles != P_PED) begin
         errors++; $display("FAIL single_dwell got=%0d exp=%0d", pedCycles, P_PED);
      end
      checks++;
      if (pulses != 2) begin
         errors++; $display("FAIL single_pulses got=%0d exp=2", pulses);
      end
   endtask

   task automatic test_round_robin();
      logic [P_NUM-1:0] seq[$];
      logic [P_NUM-1:0] prev;
      int pulses;
      curTest = "round_robin";
      doReset();
      pulses = 0; prev = '0;
      pedReq = 4'b1011; step();
      pedReq = 4'b0000; step();
      if (modeChange) pulses++;
      if (pedGrant != prev && pedGrant != 0) seq.push_back(pedGrant);
      prev = pedGrant;
      pedReq = 4'b0001;
      for (int k = 0; k < 28; k++) begin
         step();
         pedReq = 4'b0000;
         if (modeChange) pulses++;
         if (pedGrant != prev && pedGrant != 0) seq.push_back(pedGrant);
         prev = pedGrant;
      end
      checks++;
      if (seq.size() != 3) begin
         errors++; $display("FAIL rr_grant_count got=%0d exp=3", seq.size());
      end else begin
         checks++;
         if (seq[0] !== 4'b0001 || seq[1] !== 4'b0010 || seq[2] !== 4'b1000) begin
            errors++; $display("FAIL rr_order got=%b,%b,%b exp=0001,0010,1000", seq[0], seq[1], seq[2]);
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++; $display("FAIL rr_pulses got=%0d exp=2", pulses);
      end
   endtask

   task automatic test_preempt();
      int found;
      logic [P_NUM-1:0] grantAtExit;
      curTest = "preempt";
      doReset();
      pedReq = 4'b0100; step();
      pedReq = 4'b0000;
      repeat (4) step();
      emgSignal = 1'b1; step();
      checks++;
      if (modeOut !== 2'b11 || pedGrant !== 4'b0000 || pedPending[2] !== 1'b1) begin
         errors++; $display("FAIL preempt_entry got mode=%b grant=%b pend=%b exp mode=11 grant=0000 pend[2]=1",
                            modeOut, pedGrant, pedPending);
      end
      emgSignal = 1'b0; step(); step();
      emgSignal = 1'b1; step();
      emgSignal = 1'b0;
      found = 0; grantAtExit = '0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (found == 0 && modeOut == 2'b10) begin found = k; grantAtExit = pedGrant; end
      end
      checks++;
      if (found != P_EMG + 1 || grantAtExit !== 4'b0100) begin
         errors++; $display("FAIL preempt_clear got step=%0d grant=%b exp step=%0d grant=0100",
                            found, grantAtExit, P_EMG + 1);
      end
   endtask

   task automatic test_debounce();
      int found;
      curTest = "debounce";
      doReset();
      timeSignal = 1'b0; step(); step();
      timeSignal = 1'b1; repeat (4) step();
      timeSignal = 1'b0;
      found = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (found == 0 && modeOut == 2'b01) found = k;
      end
      checks++;
      if (found != P_DEB + 1) begin
         errors++; $display("FAIL debounce_latency got=%0d exp=%0d", found, P_DEB + 1);
      end
      timeSignal = 1'b1; repeat (6) step();
   endtask

   task automatic test_back_to_back();
      curTest = "back_to_back";
      timeSignal = 1'b0; pedReq = 4'b0010; emgSignal = 1'b1; step();
      pedReq = 4'b1000; step();
      pedReq = 4'b0000; emgSignal = 1'b0;
      repeat (30) step();
      timeSignal = 1'b1; repeat (6) step();
   endtask

   task automatic test_random();
      curTest = "random";
      for (int k = 0; k < 300; k++) begin
         pedReq = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         if ($urandom_range(0, 39) == 0) emgSignal = ~emgSignal;
         if ($urandom_range(0, 19) == 0) timeSignal = ~timeSignal;
         step();
      end
      pedReq = '0; emgSignal = 1'b0; timeSignal = 1'b1;
      repeat (40) step();
   endtask

   task automatic test_param_sweep();
      rstM = 1'b1;
      tick();
      checks++;
      if (modeM !== 2'b00 || chgM !== 1'b0) begin
         errors++; $display("FAIL min_idle got mode=%b chg=%b exp 00/0", modeM, chgM);
      end
      pedM = 1'b1; tick();
      checks++;
      if (pendM !== 1'b1 || modeM !== 2'b00) begin
         errors++; $display("FAIL min_latch got pend=%b mode=%b exp 1/00", pendM, modeM);
      end
      pedM = 1'b0; tick();
      checks++;
      if (modeM !== 2'b10 || grantM !== 1'b1 || pendM !== 1'b0 || chgM !== 1'b1) begin
         errors++; $display("FAIL min_grant got mode=%b grant=%b pend=%b chg=%b exp 10/1/0/1", modeM, grantM, pendM, chgM);
      end
      tick();
      checks++;
      if (modeM !== 2'b00 || grantM !== 1'b0 || chgM !== 1'b1) begin
         errors++; $display("FAIL min_dwell got mode=%b grant=%b chg=%b exp 00/0/1", modeM, grantM, chgM);
      end
      pedM = 1'b1; tick();
      pedM = 1'b0; tick();
      checks++;
      if (modeM !== 2'b10 || grantM !== 1'b1) begin
         errors++; $display("FAIL min_wrap got mode=%b grant=%b exp 10/1", modeM, grantM);
      end
      emgM = 1'b1; tick();
      checks++;
      if (modeM !== 2'b11 || grantM !== 1'b0 || pendM !== 1'b1 || chgM !== 1'b1) begin
         errors++; $display("FAIL min_preempt got mode=%b grant=%b pend=%b chg=%b exp 11/0/1/1", modeM, grantM, pendM, chgM);
      end
      emgM = 1'b0; tick();
      checks++;
      if (modeM !== 2'b10 || grantM !== 1'b1 || pendM !== 1'b0) begin
         errors++; $display("FAIL min_emg_exit_ped got mode=%b grant=%b pend=%b exp 10/1/0", modeM, grantM, pendM);
      end
      tick();
      emgM = 1'b1; tick();
      checks++;
      if (modeM !== 2'b11) begin
         errors++; $display("FAIL min_emg got mode=%b exp 11", modeM);
      end
      emgM = 1'b0; tick();
      checks++;
      if (modeM !== 2'b00 || chgM !== 1'b1) begin
         errors++; $display("FAIL min_emg_exit got mode=%b chg=%b exp 00/1", modeM, chgM);
      end
      timeM = 1'b0; tick();
      checks++;
      if (modeM !== 2'b00) begin
         errors++; $display("FAIL min_deb_hold got mode=%b exp 00", modeM);
      end
      tick();
      checks++;
      if (modeM !== 2'b01 || chgM !== 1'b1) begin
         errors++; $display("FAIL min_deb_night got mode=%b chg=%b exp 01/1", modeM, chgM);
      end
      timeM = 1'b1; tick(); tick();
      checks++;
      if (modeM !== 2'b00) begin
         errors++; $display("FAIL min_deb_day got mode=%b exp 00", modeM);
      end
   endtask

   initial begin
      rst_n = 1'b0; timeSignal = 1'b1; pedReq = '0; emgSignal = 1'b0;
      rstM = 1'b0; timeM = 1'b1; pedM = 1'b0; emgM = 1'b0;
      modelReset();
      test_reset();
      test_single_ped();
      test_round_robin();
      test_preempt();
      test_debounce();
      test_back_to_back();
      test_random();
      test_param_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
